// File: rtl/hex_line_loader.sv
// hex_line_loader: parses ASCII hex lines from a byte stream into 32-bit memory writes.
// Latency: wr_en fires exactly one cycle after the line-end byte is received.
// Backpressure: none on rx; echo bytes are dropped while the tx sink stalls.
//
// Line format: "@hhhh" sets the write address; "hhhhhhhh" writes one word at the
// current address and post-increments it; "G"/"g" at line start ends the load.
// Space/tab are ignored, CR or LF terminates a line, and anything malformed sets
// the sticky err flag and discards the rest of that line.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   rx_data/rx_valid         received byte stream, one strobe per byte
//   wr_en/wr_addr/wr_data    one-cycle memory write
//   word_cnt                 words written since reset (wraps)
//   err, done                sticky error / load-complete flags
//   tx_data/tx_valid/tx_ready  echo of each received byte
//
// Build option: define LOADER_ECHO_EN to enable the byte echo; without it the
// tx outputs are tied low and tx_ready is ignored.

module hex_line_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] word_cnt,
    output logic              err,
    output logic              done,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    typedef enum logic [2:0] {
        S_LINE,
        S_DATA,
        S_ADDR,
        S_SKIP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       accum_q, accum_d;
    logic [3:0]        ndig_q, ndig_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    // Byte classification
    logic       is_hex;
    logic [3:0] hex_val;
    logic       is_ws;
    logic       is_eol;
    logic       is_at;
    logic       is_g;

    always_comb begin
        is_hex  = 1'b0;
        hex_val = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex  = 1'b1;
            hex_val = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 lands on 10
            is_hex  = 1'b1;
            hex_val = rx_data[3:0] + 4'd9;
        end
    end

    assign is_ws  = (rx_data == 8'h20) || (rx_data == 8'h09);
    assign is_eol = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign is_at  = (rx_data == 8'h40);
    assign is_g   = (rx_data == 8'h47) || (rx_data == 8'h67);

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        accum_d   = accum_q;
        ndig_d    = ndig_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = done_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // Whitespace never changes parser state; DONE swallows everything.
        if (rx_valid && (state_q != S_DONE) && !is_ws) begin
            case (state_q)
                S_LINE: begin
                    if (is_hex) begin
                        state_d = S_DATA;
                        accum_d = {28'd0, hex_val};
                        ndig_d  = 4'd1;
                    end else if (is_at) begin
                        state_d = S_ADDR;
                        accum_d = 32'd0;
                        ndig_d  = 4'd0;
                    end else if (is_g) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (!is_eol) begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                    end
                end

                S_DATA, S_ADDR: begin
                    if (is_hex) begin
                        if (ndig_q == 4'd8) begin
                            // a ninth digit overflows the 32-bit word
                            state_d = S_SKIP;
                            err_d   = 1'b1;
                        end else begin
                            accum_d = {accum_q[27:0], hex_val};
                            ndig_d  = ndig_q + 4'd1;
                        end
                    end else if (is_eol) begin
                        state_d = S_LINE;
                        if (state_q == S_DATA) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = accum_q;
                            addr_d    = addr_q + 1'b1;
                            cnt_d     = cnt_q + 1'b1;
                        end else if (ndig_q != 4'd0) begin
                            addr_d = accum_q[ADDR_W-1:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                    end
                end

                S_SKIP: begin
                    if (is_eol) begin
                        state_d = S_LINE;
                    end
                end

                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LINE;
            accum_q   <= 32'd0;
            ndig_q    <= 4'd0;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            accum_q   <= accum_d;
            ndig_q    <= ndig_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign word_cnt = cnt_q;
    assign err      = err_q;
    assign done     = done_q;

`ifdef LOADER_ECHO_EN
    logic [7:0] tx_data_q;
    logic       tx_valid_q;

    // Every byte seen outside DONE is echoed; if the previous echo is still
    // stalled the new byte is dropped rather than queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
        end else if (rx_valid && (state_q != S_DONE) && (!tx_valid_q || tx_ready)) begin
            tx_data_q  <= rx_data;
            tx_valid_q <= 1'b1;
        end else if (tx_valid_q && tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
`else
    logic unused_tx_ready;

    assign unused_tx_ready = tx_ready;
    assign tx_data         = 8'd0;
    assign tx_valid        = 1'b0;
`endif

endmodule

// File: doc/hex_line_loader.md
HEX_LINE_LOADER -- requirements
Module: hex_line_loader

Interface
REQ-001 Parameter ADDR_W, default 16, width of the write address and word counter.
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port rx_data  input  8  received ASCII byte; valid only when rx_valid=1.
REQ-005 Port rx_valid  input  1  one-cycle strobe per received byte; no backpressure.
REQ-006 Port wr_en  output  1  one-cycle memory write strobe.
REQ-007 Port wr_addr  output  ADDR_W  write address; valid when wr_en=1.
REQ-008 Port wr_data  output  32  write data; valid when wr_en=1.
REQ-009 Port word_cnt  output  ADDR_W  number of words written since reset, wrapping.
REQ-010 Port err  output  1  sticky error flag.
REQ-011 Port done  output  1  sticky load-complete flag.
REQ-012 Port tx_data  output  8  echo byte.
REQ-013 Port tx_valid  output  1  echo byte pending.
REQ-014 Port tx_ready  input  1  echo sink accepts tx_data when tx_valid=1 and tx_ready=1.

Function
REQ-015 Hex digits SHALL be 0x30-0x39, 0x41-0x46 and 0x61-0x66, mapped to values 0-15 case-insensitively; the block SHALL decode digit validity itself.
REQ-016 Space (0x20) and tab (0x09) SHALL be ignored in every state except DONE.
REQ-017 CR (0x0D) and LF (0x0A) SHALL each act as a line end.
REQ-018 States: LINE (line start), DATA, ADDR, SKIP, DONE; reset state LINE.
REQ-019 LINE: hex digit -> DATA with accum = digit and ndig = 1; '@' (0x40) -> ADDR with accum = 0 and ndig = 0; 'G'/'g' -> DONE; line end -> stay in LINE; any other byte -> SKIP and set err.
REQ-020 DATA/ADDR: each hex digit sets accum = {accum[27:0], digit} and ndig = ndig+1.
REQ-021 DATA/ADDR: a ninth digit, or any non-hex, non-whitespace, non-line-end byte, -> SKIP and set err; no write occurs.
REQ-022 DATA: line end -> wr_en=1 on the next cycle with wr_data = accum (zero-extended) and wr_addr = addr; addr and word_cnt then increment; next state LINE.
REQ-023 ADDR: line end with ndig>=1 -> addr = accum[ADDR_W-1:0] and next state LINE; line end with ndig=0 -> set err and next state LINE.
REQ-024 SKIP: discard bytes until a line end, then go to LINE.
REQ-025 DONE: done=1; all rx bytes ignored (no echo, no write) until reset.
REQ-026 Latency from rx_valid of the line end to wr_en SHALL be exactly 1 cycle; at most one write per line.
REQ-027 addr and word_cnt SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-028 err, once set, SHALL stay set until reset; err does not block further parsing.
REQ-029 Back-to-back rx_valid on consecutive cycles SHALL be handled with no byte lost.

Reset
REQ-030 On rst: state LINE; accum, ndig, addr, word_cnt = 0; wr_en, err, done, tx_valid = 0; tx_data = 0; wr_addr and wr_data = 0.
REQ-031 rst asserted mid-line SHALL discard the partial line; no write SHALL be issued for it.

Configuration
REQ-032 Macro LOADER_ECHO_EN: when defined, each accepted rx byte (not in DONE) SHALL be loaded into tx_data with tx_valid=1 on the next cycle, if tx_valid=0 or tx_ready=1 in that cycle; otherwise the echo byte is dropped. tx_valid SHALL clear after the handshake when no new byte is loaded.
REQ-033 Without LOADER_ECHO_EN: tx_valid and tx_data SHALL be constant 0, tx_ready SHALL be ignored, and parsing is identical.

Verification
REQ-034 After reset, send "DEADBEEF\n" -> one wr_en with wr_addr=0 and wr_data=0xDEADBEEF; word_cnt=1; err=0.
REQ-035 Send "@1f\r\n", then "a\n", then "12 34\n" -> writes at 0x001F with data 0x0000000A and at 0x0020 with data 0x00001234; no write for the empty line.
REQ-036 Send "123456789\n" then "5\n" -> err=1 and no write for the first line; the second line writes 0x00000005 at addr 0.
REQ-037 Send "xyz\n7\nG\n3\n" -> err=1; one write of 7 at addr 0; done=1; no write for "3".
REQ-038 Assert rst after "AB" with no line end, then send "C\n" -> a single write of 0x0000000C at addr 0.
REQ-039 With LOADER_ECHO_EN and tx_ready=1, send "1\n" back-to-back -> tx_valid pulses carry 0x31 then 0x0A; with tx_ready=0 the second byte is dropped and tx_data stays 0x31.
